itof_sched: RTL and testbench

- Schedules shared access to one pipelined int-to-float converter (itof, fixed latency LAT) for two requesters, e.g. integer-pipe lanes.
- Round-robin arbitrates the requests, drives the converter input and tracks in-flight ops with a valid/tag shift register.
- Converter output cannot stall, so results land in a result FIFO; issue is credit-gated so the FIFO can never overflow.
- Sits between the issue stage and the FPU writeback path.

---
 rtl/itof_sched.sv | 123 ++++++++++++
 tb/tb_itof_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itof_sched.sv
// itof_sched: shares one pipelined int-to-float converter between two
// requesters. Round-robin grant, credit-gated issue, valid/tag shift
// register for in-flight ops, result FIFO on the non-stallable output.
// Optional ITOF_SCHED_PERF_EN adds perf_issue/perf_stall counters.
module itof_sched #(
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req_valid,
    input  logic [63:0] req_data,
    output logic [1:0]  req_ready,
    output logic [31:0] cvt_x,
    input  logic [31:0] cvt_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_tag,
    output logic        busy
`ifdef ITOF_SCHED_PERF_EN
    ,
    output logic [31:0] perf_issue,
    output logic [31:0] perf_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1) + 1;

    logic [LAT-1:0] r_vld_pipe;
    logic [LAT-1:0] r_tag_pipe;
    logic [CW-1:0]  r_infl;
    logic [CW-1:0]  r_fcnt;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [32:0]    r_mem [DEPTH];
    logic           r_prio;

    logic w_credit;
    logic w_issue;
    logic w_id;
    logic w_push;
    logic w_pop;

    // Credit counts only registered occupancy, so a pop frees a slot one
    // cycle later. Issue is also held off while reset is asserted.
    assign w_credit  = (r_infl + r_fcnt) < CW'(DEPTH);
    assign w_issue   = rstn & w_credit & (|req_valid);
    assign w_id      = (&req_valid) ? r_prio : req_valid[1];
    assign req_ready = w_issue ? (w_id ? 2'b10 : 2'b01) : 2'b00;
    assign cvt_x     = w_issue ? (w_id ? req_data[63:32] : req_data[31:0]) : 32'h0;

    assign w_push    = r_vld_pipe[LAT-1];
    assign rsp_valid = (r_fcnt != '0);
    assign w_pop     = rsp_valid & rsp_ready;
    assign rsp_data  = r_mem[r_rptr][31:0];
    assign rsp_tag   = r_mem[r_rptr][32];
    assign busy      = (r_infl != '0) | (r_fcnt != '0);

    // In-flight tracking: stage 0 captures this cycle's issue, then shifts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_issue;
            r_tag_pipe[0] <= w_id;
            for (int k = 1; k < LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_tag_pipe[k] <= r_tag_pipe[k-1];
            end
        end
    end

    // Occupancy counters and round-robin priority (loser wins next time).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_infl <= '0;
            r_fcnt <= '0;
            r_prio <= 1'b0;
        end else begin
            r_infl <= r_infl + CW'(w_issue) - CW'(w_push);
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
            if (w_issue) r_prio <= ~w_id;
        end
    end

    // Result FIFO storage; cleared on reset so the head reads 0 when empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {r_tag_pipe[LAT-1], cvt_y};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

`ifdef ITOF_SCHED_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    // Issue count and credit-blocked request cycles; both wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_issue) r_perf_issue <= r_perf_issue + 32'd1;
            if ((|req_valid) && !w_credit) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issue = r_perf_issue;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_itof_sched.sv
// Directed bench for itof_sched (LAT=1, DEPTH=4) with a converter model
// and an in-order scoreboard on the response side.
module tb_itof_sched;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic [31:0] cvt_x;
    logic [31:0] cvt_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_tag;
    logic        busy;
`ifdef ITOF_SCHED_PERF_EN
    logic [31:0] perf_issue;
    logic [31:0] perf_stall;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    itof_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cvt_x     (cvt_x),
        .cvt_y     (cvt_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
`ifdef ITOF_SCHED_PERF_EN
        ,
        .perf_issue(perf_issue),
        .perf_stall(perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Hand-computed IEEE single results for the operands used below.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        case (x)
            32'h0000_0000: i2f = 32'h0000_0000;
            32'h0000_0001: i2f = 32'h3F80_0000;
            32'h0000_0002: i2f = 32'h4000_0000;
            32'h0000_0003: i2f = 32'h4040_0000;
            32'h0000_0004: i2f = 32'h4080_0000;
            32'h0000_0005: i2f = 32'h40A0_0000;
            32'hFFFF_FFFE: i2f = 32'hC000_0000;
            32'h7FFF_FFFF: i2f = 32'h4F00_0000;
            32'h8000_0000: i2f = 32'hCF00_0000;
            default:       i2f = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Fixed-latency converter model.
    logic [31:0] cvt_pipe [LAT];
    always @(posedge clk) begin
        cvt_pipe[0] <= i2f(cvt_x);
        for (int k = 1; k < LAT; k++) cvt_pipe[k] <= cvt_pipe[k-1];
    end
    assign cvt_y = cvt_pipe[LAT-1];

    // Scoreboard: accepted requests in order, popped against responses.
    logic [32:0] sb_q [$];
    always @(negedge clk) begin
        if (!rstn) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                chk("sb_empty", 32'(sb_q.size() == 0), 32'd0);
                if (sb_q.size() != 0) begin
                    chk("sb_data", rsp_data, sb_q[0][31:0]);
                    chk("sb_tag", 32'(rsp_tag), 32'(sb_q[0][32]));
                    void'(sb_q.pop_front());
                end
            end
            for (int i = 0; i < 2; i++)
                if (req_valid[i] && req_ready[i])
                    sb_q.push_back({1'(i), i2f(req_data[32*i +: 32])});
            chk("credit", 32'(sb_q.size() <= DEPTH), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #2;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_d;
        logic [31:0] val;
        int          stall_exp;

        // Reset state, with a request pending to prove ready is held low.
        rstn      = 1'b0;
        req_valid = 2'b01;
        req_data  = 64'h1;
        rsp_ready = 1'b0;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        chk("rst_rsp_tag",   32'(rsp_tag),   32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        tick();
        rstn = 1'b1;

        // Single op: 1 -> 1.0f, visible two cycles after issue.
        req_valid = 2'b01;
        req_data  = 64'h1;
        rsp_ready = 1'b1;
        #1;
        chk("t1_ready", 32'(req_ready), 32'd1);
        chk("t1_cvt_x", cvt_x, 32'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
        chk("t1_busy_inflight", 32'(busy), 32'd1);
        tick();
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_data", rsp_data, 32'h3F80_0000);
        chk("t1_rsp_tag", 32'(rsp_tag), 32'd0);
        tick();
        #1;
        chk("t1_drained", 32'(rsp_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Contention: alternating grants starting with requester 0.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_data  = {32'h7FFF_FFFF, 32'hFFFF_FFFE};
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_grant", 32'(req_ready), (k % 2 != 0) ? 32'd2 : 32'd1);
            chk("t2_cvt_x", cvt_x, (k % 2 != 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFE);
            if (k >= 2) begin
                exp_d = (k % 2 != 0) ? 32'h4F00_0000 : 32'hC000_0000;
                chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("t2_rsp_data", rsp_data, exp_d);
                chk("t2_rsp_tag", 32'(rsp_tag), 32'(k % 2));
            end
            tick();
        end
        req_valid = 2'b00;
        #1;
        chk("t2_tail0", rsp_data, 32'hC000_0000);
        tick();
        #1;
        chk("t2_tail1", rsp_data, 32'h4F00_0000);
        chk("t2_tail1_tag", 32'(rsp_tag), 32'd1);
        tick();
        #1;
        chk("t2_idle", 32'(busy), 32'd0);

        // Backpressure: four accepted, then credit-blocked until a pop.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        val       = 32'd1;
        stall_exp = 0;
        for (int c = 0; c < 8; c++) begin
            req_data = {32'h0, val};
            #1;
            if (c < 4) begin
                chk("t3_accept", 32'(req_ready), 32'd1);
                chk("t3_cvt_x", cvt_x, val);
                val = val + 32'd1;
            end else begin
                chk("t3_blocked", 32'(req_ready), 32'd0);
                chk("t3_busy", 32'(busy), 32'd1);
                stall_exp++;
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_pop_no_credit", 32'(req_ready), 32'd0);
        chk("t3_head0", rsp_data, 32'h3F80_0000);
        stall_exp++;
        tick();
        #1;
        chk("t3_fifth_issue", 32'(req_ready), 32'd1);
        chk("t3_fifth_x", cvt_x, 32'd5);
        chk("t3_head1", rsp_data, 32'h4000_0000);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t3_head2", rsp_data, 32'h4040_0000);
`ifdef ITOF_SCHED_PERF_EN
        chk("perf_issue", perf_issue, 32'd5);
        chk("perf_stall", perf_stall, 32'(stall_exp));
`endif
        tick();
        #1;
        chk("t3_head3", rsp_data, 32'h4080_0000);
        tick();
        #1;
        chk("t3_head4", rsp_data, 32'h40A0_0000);
        tick();
        #1;
        chk("t3_empty", 32'(rsp_valid), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);

        // Edge values from requester 1: zero and INT_MIN.
        rsp_ready = 1'b1;
        req_valid = 2'b10;
        req_data  = {32'h0000_0000, 32'h0};
        #1;
        chk("t4_grant0", 32'(req_ready), 32'd2);
        tick();
        req_data = {32'h8000_0000, 32'h0};
        #1;
        chk("t4_grant1", 32'(req_ready), 32'd2);
        chk("t4_cvt_x", cvt_x, 32'h8000_0000);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t4_zero", rsp_data, 32'h0000_0000);
        chk("t4_zero_valid", 32'(rsp_valid), 32'd1);
        chk("t4_zero_tag", 32'(rsp_tag), 32'd1);
        tick();
        #1;
        chk("t4_min", rsp_data, 32'hCF00_0000);
        chk("t4_min_tag", 32'(rsp_tag), 32'd1);
        tick();

        // Reset mid-flight: 3 queued, 1 in flight, asserted between edges.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            req_data = {32'h0, 32'(c + 1)};
            tick();
        end
        #1;
        chk("t5_full_valid", 32'(rsp_valid), 32'd1);
        chk("t5_full_ready", 32'(req_ready), 32'd0);
        #1;
        rstn = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_data", rsp_data, 32'd0);
        tick();
        rstn      = 1'b1;
        req_data  = 64'h3;
        rsp_ready = 1'b1;
        #1;
        chk("t5_new_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t5_no_stale", 32'(rsp_valid), 32'd0);
        tick();
        #1;
        chk("t5_new_rsp", rsp_data, 32'h4040_0000);
        chk("t5_new_tag", 32'(rsp_tag), 32'd0);
        tick();
        #1;
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_empty", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
